// File: rtl/rf_cmd_pkg.sv
// Shared opcodes, FSM state encoding and defaults for the
// register-file command controller.
package rf_cmd_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [7:0] WR_CMD = 8'hAA;
    localparam logic [7:0] RD_CMD = 8'hBB;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_ISSUE,
        RD_WAIT,
        TX_SEND
    } state_t;

    // States in which the next byte of a command is awaited
    function automatic logic waits_for_byte(input state_t s);
        return s inside {WR_ADDR, WR_DATA, RD_ADDR};
    endfunction

    // States in which a read is in flight and new bytes overrun
    function automatic logic read_in_flight(input state_t s);
        return s inside {RD_ISSUE, RD_WAIT, TX_SEND};
    endfunction

endpackage

// File: rtl/rf_cmd_timer.sv
// Inter-byte idle timer: loadable down-counter with clear,
// flagging expiry on the last counted idle cycle.
module rf_cmd_timer #(
    parameter int TIMEOUT = 1024,
    localparam int CNT_W = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = LOAD_V;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - ONE_V;
        end
    end

    assign expire_o = en_i && !clr_i && !load_i && (cnt_q == ONE_V);

endmodule

// File: rtl/rf_cmd_ctrl.sv
// Byte-stream command parser driving register-file write/read
// strobes and returning read data over a valid/busy handshake.
module rf_cmd_ctrl
    import rf_cmd_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rf_wren,
    output logic              rf_rden,
    output logic [ADDR_W-1:0] rf_address,
    output logic [DATA_W-1:0] rf_wrdata,
    input  logic [DATA_W-1:0] rf_rddata,
    input  logic              rf_rddata_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_busy,
    output logic              cmd_error
);

    localparam logic [DATA_W-1:0] DEPTH_B = DATA_W'(DEPTH);
    localparam logic [DATA_W-1:0] WR_B    = DATA_W'(WR_CMD);
    localparam logic [DATA_W-1:0] RD_B    = DATA_W'(RD_CMD);

    state_t            state_q, state_d;
    logic              wren_q, wren_d;
    logic              rden_q, rden_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;
    logic [DATA_W-1:0] txd_q, txd_d;
    logic              txv_q, txv_d;
    logic              err_q, err_d;

    logic waiting;
    logic expire;
    logic in_range;

    assign waiting  = waits_for_byte(state_q);
    assign in_range = rx_data < DEPTH_B;

    // Any received byte restarts the idle window
    rf_cmd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!waiting && !rx_valid),
        .load_i   (rx_valid),
        .en_i     (waiting && !rx_valid),
        .expire_o (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            addr_q   <= '0;
            wrdata_q <= '0;
            txd_q    <= '0;
            txv_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            txd_q    <= txd_d;
            txv_q    <= txv_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        txd_d    = txd_q;
        txv_d    = txv_q;
        err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == WR_B) begin
                        state_d = WR_ADDR;
                    end else if (rx_data == RD_B) begin
                        state_d = RD_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (rx_valid) begin
                    if (in_range) begin
                        addr_d  = rx_data[ADDR_W-1:0];
                        rden_d  = (state_q == RD_ADDR);
                        state_d = (state_q == WR_ADDR) ? WR_DATA : RD_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_DATA: begin
                if (rx_valid) begin
                    wrdata_d = rx_data;
                    wren_d   = 1'b1;
                    state_d  = IDLE;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (rf_rddata_valid) begin
                    txd_d   = rf_rddata;
                    txv_d   = 1'b1;
                    state_d = TX_SEND;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            TX_SEND: begin
                if (!tx_busy) begin
                    txv_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bytes arriving mid-read are dropped without disturbing it
        if (rx_valid && read_in_flight(state_q)) begin
            err_d = 1'b1;
        end
    end

    assign rf_wren    = wren_q;
    assign rf_rden    = rden_q;
    assign rf_address = addr_q;
    assign rf_wrdata  = wrdata_q;
    assign tx_data    = txd_q;
    assign tx_valid   = txv_q;
    assign cmd_error  = err_q;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Directed plus randomized bench for rf_cmd_ctrl against a
// behavioural register-file scoreboard.
module tb_rf_cmd_ctrl;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 1024;

    localparam logic [7:0] INIT [16] = '{
        8'h10, 8'h27, 8'h81, 8'h5A, 8'hC3, 8'h09, 8'h77, 8'hE4,
        8'h3B, 8'h92, 8'h6D, 8'h01, 8'hFE, 8'h48, 8'hB5, 8'h2C
    };

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rf_wren;
    logic       rf_rden;
    logic [3:0] rf_address;
    logic [7:0] rf_wrdata;
    logic [7:0] rf_rddata;
    logic       rf_rddata_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_busy;
    logic       cmd_error;

    int n_checks = 0;
    int n_fail   = 0;

    int n_wr   = 0;
    int n_rd   = 0;
    int n_both = 0;
    int n_acc  = 0;

    logic [7:0] rf_mem [16] = INIT;
    logic [7:0] exp_mem [16];

    rf_cmd_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rf_wren         (rf_wren),
        .rf_rden         (rf_rden),
        .rf_address      (rf_address),
        .rf_wrdata       (rf_wrdata),
        .rf_rddata       (rf_rddata),
        .rf_rddata_valid (rf_rddata_valid),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_busy         (tx_busy),
        .cmd_error       (cmd_error)
    );

    always #5 clk = ~clk;

    // Register file: registered read data, sticky valid flag
    initial rf_rddata = 8'h00;
    initial rf_rddata_valid = 1'b0;
    always @(posedge clk) begin
        if (rf_wren) rf_mem[rf_address] <= rf_wrdata;
        if (rf_rden) begin
            rf_rddata       <= rf_mem[rf_address];
            rf_rddata_valid <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (rf_wren) n_wr <= n_wr + 1;
            if (rf_rden) n_rd <= n_rd + 1;
            if (rf_wren && rf_rden) n_both <= n_both + 1;
            if (tx_valid && !tx_busy) n_acc <= n_acc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int g);
        repeat (g) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".wren"}, rf_wren, 0);
        chk({tag, ".rden"}, rf_rden, 0);
        chk({tag, ".addr"}, rf_address, 0);
        chk({tag, ".wrdata"}, rf_wrdata, 0);
        chk({tag, ".txdata"}, tx_data, 0);
        chk({tag, ".txvalid"}, tx_valid, 0);
        chk({tag, ".err"}, cmd_error, 0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d,
                            input int g);
        int wr0;
        wr0 = n_wr;
        send(8'hAA);
        gap(g);
        send({4'h0, a});
        gap(g);
        send(d);
        chk("wr.wren", rf_wren, 1);
        chk("wr.addr", rf_address, a);
        chk("wr.data", rf_wrdata, d);
        chk("wr.err", cmd_error, 0);
        exp_mem[a] = d;
        @(negedge clk);
        chk("wr.pulses", n_wr - wr0, 1);
        chk("wr.wren_drop", rf_wren, 0);
    endtask

    task automatic do_read(input logic [3:0] a, input int busy, input int g);
        int acc0;
        acc0    = n_acc;
        tx_busy = (busy != 0);
        send(8'hBB);
        gap(g);
        send({4'h0, a});
        chk("rd.rden", rf_rden, 1);
        chk("rd.addr", rf_address, a);
        @(negedge clk);
        chk("rd.rden_drop", rf_rden, 0);
        chk("rd.early_valid", tx_valid, 0);
        @(negedge clk);
        chk("rd.valid", tx_valid, 1);
        chk("rd.data", tx_data, exp_mem[a]);
        for (int i = 0; i < busy; i++) begin
            @(negedge clk);
            chk("rd.hold_valid", tx_valid, 1);
            chk("rd.hold_data", tx_data, exp_mem[a]);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        chk("rd.valid_drop", tx_valid, 0);
        chk("rd.accepts", n_acc - acc0, 1);
    endtask

    initial begin
        int n;
        int wr0;
        exp_mem  = INIT;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        gap(3);
        chk_reset_vals("reset");
        rst = 1'b0;
        gap(2);

        do_write(4'd5, 8'h3C, 0);
        do_read(4'd2, 0, 0);
        do_read(4'd2, 10, 1);

        send(8'h55);
        chk("badop.err", cmd_error, 1);
        @(negedge clk);
        chk("badop.err_drop", cmd_error, 0);

        wr0 = n_wr;
        send(8'hAA);
        send(8'h10);
        chk("badaddr.err", cmd_error, 1);
        gap(3);
        chk("badaddr.no_wr", n_wr - wr0, 0);

        send(8'hAA);
        n = 0;
        while (!cmd_error && n < TIMEOUT + 10) begin
            @(negedge clk);
            n++;
        end
        chk("timeout.cycles", n, TIMEOUT);
        chk("timeout.no_wr", n_wr - wr0, 0);
        @(negedge clk);
        do_read(4'd3, 0, 0);

        // Byte arriving while the response is pending
        tx_busy = 1'b1;
        send(8'hBB);
        send(8'h07);
        gap(2);
        chk("ovr.valid_pre", tx_valid, 1);
        send(8'h12);
        chk("ovr.err", cmd_error, 1);
        chk("ovr.valid", tx_valid, 1);
        chk("ovr.data", tx_data, exp_mem[7]);
        tx_busy = 1'b0;
        gap(2);
        chk("ovr.done", tx_valid, 0);

        // Reset while the response is being held
        wr0     = n_wr;
        n       = n_rd;
        tx_busy = 1'b1;
        send(8'hBB);
        send(8'h02);
        gap(2);
        chk("rstrd.valid_pre", tx_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rstrd");
        rst     = 1'b0;
        tx_busy = 1'b0;
        gap(2);
        chk("rstrd.no_wr", n_wr - wr0, 0);
        chk("rstrd.one_rd", n_rd - n, 1);
        do_write(4'd1, 8'hFF, 0);
        do_read(4'd1, 0, 0);

        for (int t = 0; t < 40; t++) begin
            logic [3:0] a;
            logic [7:0] d;
            a = 4'($urandom_range(0, DEPTH - 1));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, d, $urandom_range(0, 3));
            end else begin
                do_read(a, $urandom_range(0, 4), $urandom_range(0, 3));
            end
            gap($urandom_range(0, 2));
        end

        chk("never_both", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
